// File: rtl/exe_pkg.sv
// Shared types and encodings for the execute stage and its multiply/divide unit.
package exe_pkg;

  // Multiply/divide sequencer states.
  typedef enum logic [1:0] {
    MdIdle,
    MdBusy,
    MdDone
  } md_state_t;

  // M-extension funct3 encodings.
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // Writeback source select carried to the memory stage.
  typedef enum logic [1:0] {
    ResAlu = 2'b00,
    ResMem = 2'b01,
    ResPc4 = 2'b10
  } res_src_t;

endpackage

// File: rtl/md_unit.sv
// Iterative radix-2 multiply/divide unit. Fixed XLEN-cycle latency: shift-add multiply on a
// 2*XLEN accumulator, restoring divide on operand magnitudes, sign fix-up applied on output.
module md_unit
  import exe_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned CNTW = $clog2(XLEN) + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic            hold_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            idle_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  md_state_t         state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  // Multiplicand for multiply, divisor for divide.
  logic [XLEN-1:0]   opnd_q, opnd_d;
  // Multiply: {product_hi, multiplier/product_lo}. Divide: {remainder, dividend/quotient}.
  logic [2*XLEN-1:0] acc_q, acc_d;

  logic              a_sgn, b_sgn, neg_start;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN-1:0]   mul_add;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_shift, div_diff;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo_s, rem_s;

  // Decode operand signedness and final result sign at issue time.
  always_comb begin
    a_sgn     = 1'b0;
    b_sgn     = 1'b0;
    neg_start = 1'b0;
    case (funct3_i)
      F3_MULH: begin
        a_sgn     = 1'b1;
        b_sgn     = 1'b1;
        neg_start = a_i[XLEN-1] ^ b_i[XLEN-1];
      end
      F3_MULHSU: begin
        a_sgn     = 1'b1;
        neg_start = a_i[XLEN-1];
      end
      F3_DIV: begin
        a_sgn     = 1'b1;
        b_sgn     = 1'b1;
        // Divide by zero yields all-ones regardless of dividend sign.
        neg_start = (a_i[XLEN-1] ^ b_i[XLEN-1]) & (|b_i);
      end
      F3_REM: begin
        a_sgn     = 1'b1;
        b_sgn     = 1'b1;
        neg_start = a_i[XLEN-1];
      end
      default: ;
    endcase
    a_mag = (a_sgn && a_i[XLEN-1]) ? -a_i : a_i;
    b_mag = (b_sgn && b_i[XLEN-1]) ? -b_i : b_i;
  end

  // One radix-2 step for each operation kind.
  assign mul_add   = acc_q[0] ? opnd_q : '0;
  assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mul_add};
  assign mul_next  = {mul_sum, acc_q[XLEN-1:1]};
  assign div_shift = acc_q[2*XLEN-1:XLEN-1];
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                    : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

  // Sequencer next state; flush overrides every transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    unique case (state_q)
      MdIdle: begin
        if (start_i && !flush_i) begin
          state_d = MdBusy;
          cnt_d   = CNTW'(XLEN);
          op_d    = funct3_i;
          neg_d   = neg_start;
          if (!funct3_i[2]) begin
            opnd_d = a_mag;
            acc_d  = {{XLEN{1'b0}}, b_mag};
          end else begin
            opnd_d = b_mag;
            acc_d  = {{XLEN{1'b0}}, a_mag};
          end
        end
      end
      MdBusy: begin
        if (flush_i) begin
          state_d = MdIdle;
          cnt_d   = '0;
        end else begin
          acc_d = op_q[2] ? div_next : mul_next;
          cnt_d = cnt_q - CNTW'(1);
          if (cnt_q == CNTW'(1)) state_d = MdDone;
        end
      end
      MdDone: begin
        if (flush_i) begin
          state_d = MdIdle;
          cnt_d   = '0;
        end else if (!hold_i) begin
          state_d = MdIdle;
        end
      end
      default: begin
        state_d = MdIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Sequencer and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= MdIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      opnd_q  <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
    end
  end

  // Sign fix-up and result select from the settled accumulator.
  always_comb begin
    prod  = neg_q ? -acc_q : acc_q;
    quo_s = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_s = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      F3_MUL:                      result_o = prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: result_o = prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:             result_o = quo_s;
      default:                     result_o = rem_s;
    endcase
  end

  assign idle_o = (state_q == MdIdle);
  assign busy_o = (state_q == MdBusy);
  assign done_o = (state_q == MdDone);

endmodule

// File: rtl/execute_stage_md.sv
// Execute stage: muxes the multiply/divide result over the ALU result, stalls upstream while
// the M unit works, and registers the instruction into EX/MEM.
module execute_stage_md
  import exe_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned REGW = 5,
  localparam int unsigned CNTW = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_e,
  input  logic            md_en_e,
  input  logic [2:0]      funct3_e,
  input  logic [XLEN-1:0] src_a_e,
  input  logic [XLEN-1:0] src_b_e,
  input  logic [XLEN-1:0] alu_result_e,
  input  logic [XLEN-1:0] write_data_e,
  input  logic [REGW-1:0] rd_e,
  input  logic            reg_write_e,
  input  logic            mem_write_e,
  input  logic [1:0]      result_src_e,
  input  logic            stall_m,
  input  logic            flush_e,
  output logic            stall_e,
  output logic            md_busy,
  output logic            valid_m,
  output logic            reg_write_m,
  output logic            mem_write_m,
  output logic [1:0]      result_src_m,
  output logic [XLEN-1:0] result_m,
  output logic [XLEN-1:0] write_data_m,
  output logic [REGW-1:0] rd_m
);

  logic            md_start, md_idle, md_busy_st, md_done;
  logic [XLEN-1:0] md_result;

  logic            valid_m_q, valid_m_d;
  logic            reg_write_m_q, reg_write_m_d;
  logic            mem_write_m_q, mem_write_m_d;
  logic [1:0]      result_src_m_q, result_src_m_d;
  logic [XLEN-1:0] result_m_q, result_m_d;
  logic [XLEN-1:0] write_data_m_q, write_data_m_d;
  logic [REGW-1:0] rd_m_q, rd_m_d;

  assign md_start = valid_e & md_en_e;

  md_unit #(
    .XLEN (XLEN),
    .CNTW (CNTW)
  ) u_md_unit (
    .clk_i    (clk),
    .rst_ni   (reset),
    .start_i  (md_start),
    .flush_i  (flush_e),
    .hold_i   (stall_m),
    .funct3_i (funct3_e),
    .a_i      (src_a_e),
    .b_i      (src_b_e),
    .idle_o   (md_idle),
    .busy_o   (md_busy_st),
    .done_o   (md_done),
    .result_o (md_result)
  );

  assign stall_e = (md_idle & md_start & ~flush_e) | md_busy_st | stall_m;
  assign md_busy = ~md_idle;

  // EX/MEM next state: hold on downstream stall, bubble unless a complete instruction is ready.
  always_comb begin
    valid_m_d      = valid_m_q;
    reg_write_m_d  = reg_write_m_q;
    mem_write_m_d  = mem_write_m_q;
    result_src_m_d = result_src_m_q;
    result_m_d     = result_m_q;
    write_data_m_d = write_data_m_q;
    rd_m_d         = rd_m_q;
    if (!stall_m) begin
      if (flush_e || !valid_e || (md_en_e && !md_done)) begin
        valid_m_d      = 1'b0;
        reg_write_m_d  = 1'b0;
        mem_write_m_d  = 1'b0;
        result_src_m_d = ResAlu;
        result_m_d     = '0;
        write_data_m_d = '0;
        rd_m_d         = '0;
      end else begin
        valid_m_d      = 1'b1;
        reg_write_m_d  = reg_write_e;
        mem_write_m_d  = mem_write_e;
        result_src_m_d = result_src_e;
        result_m_d     = md_done ? md_result : alu_result_e;
        write_data_m_d = write_data_e;
        rd_m_d         = rd_e;
      end
    end
  end

  // EX/MEM pipeline register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_m_q      <= 1'b0;
      reg_write_m_q  <= 1'b0;
      mem_write_m_q  <= 1'b0;
      result_src_m_q <= '0;
      result_m_q     <= '0;
      write_data_m_q <= '0;
      rd_m_q         <= '0;
    end else begin
      valid_m_q      <= valid_m_d;
      reg_write_m_q  <= reg_write_m_d;
      mem_write_m_q  <= mem_write_m_d;
      result_src_m_q <= result_src_m_d;
      result_m_q     <= result_m_d;
      write_data_m_q <= write_data_m_d;
      rd_m_q         <= rd_m_d;
    end
  end

  assign valid_m      = valid_m_q;
  assign reg_write_m  = reg_write_m_q;
  assign mem_write_m  = mem_write_m_q;
  assign result_src_m = result_src_m_q;
  assign result_m     = result_m_q;
  assign write_data_m = write_data_m_q;
  assign rd_m         = rd_m_q;

endmodule

// File: doc/execute_stage_md.md
Name: execute_stage_md

Overview:
- Parametrised next-generation execute stage with an integrated iterative multiply/divide unit (RV32M/RV64M) and EX/MEM pipeline register.
- Takes post-forwarding operands and an externally computed ALU result.
- Muxes in the multiply/divide result, stalls upstream while the unit is busy, and honours downstream stall and EX flush.
- Sits between the ID/EX register and the memory stage.

Parameters:
- XLEN, 32, datapath width (32 or 64).
- REGW, 5, register index width.
- CNTW, $clog2(XLEN)+1, iteration counter width (derived; do not override).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- valid_e  in  1  EX holds a valid instruction
- md_en_e  in  1  instruction is an M-extension op
- funct3_e  in  3  M-op select
- src_a_e  in  XLEN  forwarded operand A
- src_b_e  in  XLEN  forwarded operand B
- alu_result_e  in  XLEN  ALU result for non-M ops
- write_data_e  in  XLEN  forwarded store data
- rd_e  in  REGW  destination register
- reg_write_e, mem_write_e  in  1 each  control
- result_src_e  in  2  writeback select
- stall_m  in  1  memory stage cannot accept
- flush_e  in  1  squash the EX instruction
- stall_e  out  1  hold PC/IF/ID/ID-EX
- md_busy  out  1  state != IDLE
- valid_m, reg_write_m, mem_write_m  out  1 each
- result_src_m  out  2
- result_m, write_data_m  out  XLEN
- rd_m  out  REGW

Behaviour:
- Reset (reset=0, async): FSM=IDLE, counter=0, all EX/MEM outputs 0, stall_e=0, md_busy=0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE -> BUSY when valid_e & md_en_e & !flush_e. Operands and funct3 are latched; counter=XLEN.
  - BUSY: one radix-2 step per cycle (shift-add multiply, restoring divide on magnitudes), counter decrements. When counter reaches 1, the next state is DONE.
  - DONE -> IDLE when !stall_m. Stay in DONE while stall_m.
  - flush_e in BUSY or DONE -> IDLE and counter cleared. flush_e has priority over every other transition.
- stall_e = (IDLE & valid_e & md_en_e & !flush_e) | BUSY | stall_m.
- Fixed latency, independent of operand values:
  - op accepted at cycle t;
  - BUSY for cycles t+1..t+XLEN;
  - DONE at t+XLEN+1, with stall_e=0 in that cycle if !stall_m;
  - result visible on result_m at t+XLEN+2.
- EX/MEM register:
  - updates only when !stall_m;
  - loads a bubble (valid_m=0, reg_write_m=0, mem_write_m=0, data 0) when flush_e, !valid_e, or an M op is not in DONE;
  - otherwise loads the instruction, with result = DONE ? md_result : alu_result_e.
- When stall_m=1, all *_m outputs hold.
- M-op functions (funct3):
  - 000 MUL: low XLEN bits.
  - 001 MULH: signed×signed high.
  - 010 MULHSU: signed×unsigned high.
  - 011 MULHU: unsigned high.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Signed ops: operate on magnitudes, then negate the result. Quotient sign = sa^sb; remainder sign = sign of dividend.
- Divide by zero: quotient all-ones; remainder = dividend. Same latency as any other op.
- Signed overflow (min-int / -1): quotient = min-int; remainder = 0.
- Multiply uses a 2×XLEN internal accumulator. No other intermediate widening.
- A back-to-back M op after DONE is accepted from IDLE on the following cycle, one idle cycle minimum.
- Reset asserted mid-operation: immediate return to IDLE with all outputs cleared. No partial result is ever written.

Decomposition:
- Shared package exe_pkg holds:
  - FSM state enum (md_state_t);
  - M funct3 localparams (F3_MUL..F3_REMU);
  - result_src encodings.
- Sub-module md_unit: iterative multiply/divide with start, flush, funct3, operands, done, result. The FSM and counter live in it.
- execute_stage_md adds the stall logic, result mux and EX/MEM register.

Test Plan (XLEN=32):
- MUL 7 × 0xFFFFFFFD -> result_m=0xFFFFFFEB at cycle t+34; stall_e high t..t+32.
- MULH 0x80000000 × 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0.
- DIVU 0x1234 / 0 -> 0xFFFFFFFF; REMU -> 0x1234; latency identical to a normal divide.
- stall_m held 3 cycles in DONE -> FSM stays DONE, *_m hold, result lands after release. flush_e at BUSY cycle 10 -> IDLE next cycle, bubble in EX/MEM, no reg_write_m.
- Assert reset mid-BUSY -> all outputs 0 immediately. After release, a non-M ADD (alu_result_e=0x55) passes with 1-cycle latency and stall_e=0.
